// File: rtl/prog_load_pkg.sv
// Shared types and defaults for the UART program loader.
package prog_load_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERROR
   } state_e;

   localparam int unsigned DEF_TIMEOUT_CYCLES = 10_000_000;
   localparam int unsigned DEF_MAX_WORDS      = 16384;

   function automatic logic is_busy(input state_e s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == WRITE);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four received bytes into a little-endian 32-bit word.
module word_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic        word_ready,
   output logic [31:0] word_o
);

   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_q, word_d;

   // New bytes enter at the top so the first byte ends up in [7:0].
   always_comb begin
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      word_ready = 1'b0;
      if (clear) begin
         byte_idx_d = 2'd0;
      end else if (shift_en) begin
         word_d     = {byte_in, word_q[31:8]};
         byte_idx_d = byte_idx_q + 2'd1;
         word_ready = (byte_idx_q == 2'd3);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         byte_idx_q <= 2'd0;
         word_q     <= 32'd0;
      end else begin
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Loads a length-prefixed program image from a byte stream into the program ROM
// while holding the CPU in reset.
//
// state  | meaning
// IDLE   | CPU owns ROM, waiting for start
// LEN_LO | waiting for low byte of word count
// LEN_HI | waiting for high byte of word count
// DATA   | assembling a 4-byte word
// WRITE  | one-cycle ROM write strobe
// DONE   | load finished, CPU released after one cycle
// ERROR  | load aborted (oversize or timeout)
module prog_load_ctrl
   import prog_load_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        upg_rst_o,
   output logic        upg_wen_o,
   output logic [13:0] upg_adr_o,
   output logic [31:0] upg_dat_o,
   output logic        upg_done_o,
   output logic        cpu_rst_o,
   output logic        busy,
   output logic        err
);

   localparam int unsigned    TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]    MAX_WORDS_L = 17'(MAX_WORDS);

   state_e             state_q, state_d;
   logic [14:0]        word_idx_q, word_idx_d;
   logic [15:0]        len_q, len_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               cpu_rst_q, cpu_rst_d;

   logic               rx_fire;
   logic               restart;
   logic               asm_shift;
   logic               asm_clear;
   logic               word_ready;
   logic [31:0]        asm_word;
   logic [14:0]        idx_inc;
   logic [15:0]        len_new;

   assign rx_ready  = (state_q != WRITE);
   assign rx_fire   = rx_valid && rx_ready;
   assign restart   = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
   assign asm_shift = (state_q == DATA) && rx_fire;
   // A partial word is dropped when the load times out.
   assign asm_clear = restart || ((state_q == DATA) && !rx_fire && (tmo_q == '0));
   assign idx_inc   = word_idx_q + 15'd1;
   assign len_new   = {rx_data, len_q[7:0]};

   word_assembler u_asm (
      .clock      (clock),
      .reset      (reset),
      .clear      (asm_clear),
      .shift_en   (asm_shift),
      .byte_in    (rx_data),
      .word_ready (word_ready),
      .word_o     (asm_word)
   );

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      len_d      = len_q;
      tmo_d      = tmo_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d    = LEN_LO;
               word_idx_d = 15'd0;
               len_d      = 16'd0;
            end
         end
         LEN_LO: begin
            if (rx_fire) begin
               len_d[7:0] = rx_data;
               tmo_d      = TMO_RELOAD;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (rx_fire) begin
               len_d = len_new;
               tmo_d = TMO_RELOAD;
               if (len_new == 16'd0)                     state_d = DONE;
               else if ({1'b0, len_new} > MAX_WORDS_L)   state_d = ERROR;
               else                                      state_d = DATA;
            end else if (tmo_q == '0) begin
               state_d = ERROR;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         DATA: begin
            if (rx_fire) begin
               tmo_d = TMO_RELOAD;
               if (word_ready) state_d = WRITE;
            end else if (tmo_q == '0) begin
               state_d = ERROR;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         WRITE: begin
            word_idx_d = idx_inc;
            state_d    = ({1'b0, idx_inc} == len_q) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase
      // CPU reset covers the whole load, all of ERROR, and the first DONE cycle.
      cpu_rst_d = is_busy(state_d) || (state_d == ERROR) ||
                  ((state_d == DONE) && (state_q != DONE));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         word_idx_q <= 15'd0;
         len_q      <= 16'd0;
         tmo_q      <= '0;
         cpu_rst_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         len_q      <= len_d;
         tmo_q      <= tmo_d;
         cpu_rst_q  <= cpu_rst_d;
      end
   end

   assign busy       = is_busy(state_q);
   assign upg_rst_o  = !busy;
   assign upg_wen_o  = (state_q == WRITE);
   assign upg_adr_o  = word_idx_q[13:0];
   assign upg_dat_o  = asm_word;
   assign upg_done_o = (state_q == DONE);
   assign err        = (state_q == ERROR);
   assign cpu_rst_o  = cpu_rst_q;

endmodule
